// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package regfile_arb_pkg;
  localparam int REG_DATA_W   = 8;
  localparam int REG_ADDR_W   = 3;
  localparam int REG_INADDR_W = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [REG_INADDR_W-1:0] zext_addr(input logic [REG_ADDR_W-1:0] idx);
    return {{(REG_INADDR_W-REG_ADDR_W){1'b0}}, idx};
  endfunction
endpackage

// File: rtl/regfile_arb_fifo.sv
// Pending-write FIFO: dual push (a before b), single pop, with a per-entry
// valid/address view so pending destinations can be compared against reads.
module regfile_arb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_a,
  input  wr_req_t                      din_a,
  input  logic                         push_b,
  input  wr_req_t                      din_b,
  input  logic                         pop,
  output wr_req_t                      head,
  output logic [$clog2(DEPTH):0]       count,
  output logic [$clog2(DEPTH):0]       count_next,
  output logic                         drop,
  output logic [DEPTH-1:0]             entry_vld,
  output logic [DEPTH*REG_ADDR_W-1:0]  entry_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;
  logic          ok_a;
  logic          ok_b;
  int            room;

  // A pop on the same edge frees its entry for the pushes.
  always_comb begin
    pop_ok     = pop && (count != '0);
    room       = DEPTH - int'(count) + int'(pop_ok);
    ok_a       = push_a && (room > 0);
    ok_b       = push_b && ((room - int'(ok_a)) > 0);
    drop       = (push_a && !ok_a) || (push_b && !ok_b);
    count_next = count - CW'(pop_ok) + CW'(ok_a) + CW'(ok_b);
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (pop_ok) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (ok_a) entry_vld[wr_ptr] <= 1'b1;
      if (ok_b) entry_vld[wr_ptr + PW'(ok_a)] <= 1'b1;
      wr_ptr <= wr_ptr + PW'(ok_a) + PW'(ok_b);
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (ok_a) mem[wr_ptr] <= din_a;
    if (ok_b) mem[wr_ptr + PW'(ok_a)] <= din_b;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign entry_addr[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].addr;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-return writebacks onto the single reg_file write port.
// Define REGFILE_WRITE_ARBITER_SCOREBOARD_EN to drive HAZARD from pending writes.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BUSYWAIT,
  input  logic                    ALU_WREN,
  input  logic [ADDR_W-1:0]       ALU_ADDR,
  input  logic [DATA_W-1:0]       ALU_DATA,
  input  logic                    MEM_WREN,
  input  logic [ADDR_W-1:0]       MEM_ADDR,
  input  logic [DATA_W-1:0]       MEM_DATA,
  input  logic [ADDR_W-1:0]       RD1_ADDR,
  input  logic [ADDR_W-1:0]       RD2_ADDR,
  output logic                    RF_WRITE,
  output logic [REG_INADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0]       RF_IN,
  output logic                    STALL,
  output logic [ADDR_W:0]         PENDING,
  output logic                    OVERFLOW,
  output logic                    HAZARD
);
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int PEND_W = ADDR_W + 1;

  wr_req_t                    mem_wr;
  wr_req_t                    alu_wr;
  wr_req_t                    head;
  wr_req_t                    din_a;
  wr_req_t                    din_b;
  wr_req_t                    issue_req;
  logic                       retire;
  logic                       slot_free;
  logic                       mem_req;
  logic                       alu_req;
  logic                       push_a;
  logic                       push_b;
  logic                       pop;
  logic                       issue;
  logic                       rf_write_next;
  logic                       drop;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_next;
  logic [DEPTH-1:0]           entry_vld;
  logic [DEPTH*ADDR_W-1:0]    entry_addr;

  assign mem_wr    = '{addr: MEM_ADDR, data: MEM_DATA};
  assign alu_wr    = '{addr: ALU_ADDR, data: ALU_DATA};
  assign retire    = RF_WRITE && !BUSYWAIT;
  assign slot_free = !RF_WRITE || retire;
  assign mem_req   = MEM_WREN;
  assign alu_req   = ALU_WREN && !BUSYWAIT && !STALL;

  // Oldest candidate goes to the slot: FIFO head, then MEM, then ALU; the rest queue.
  always_comb begin
    pop       = 1'b0;
    push_a    = 1'b0;
    push_b    = 1'b0;
    din_a     = mem_wr;
    din_b     = alu_wr;
    issue     = 1'b0;
    issue_req = head;
    if (slot_free && (count != '0)) begin
      pop    = 1'b1;
      issue  = 1'b1;
      push_a = mem_req;
      push_b = alu_req;
    end else if (slot_free && mem_req) begin
      issue     = 1'b1;
      issue_req = mem_wr;
      push_a    = alu_req;
      din_a     = alu_wr;
    end else if (slot_free && alu_req) begin
      issue     = 1'b1;
      issue_req = alu_wr;
    end else begin
      push_a = mem_req;
      push_b = alu_req;
    end
  end

  assign rf_write_next = slot_free ? issue : RF_WRITE;

  regfile_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push_a    (push_a),
    .din_a     (din_a),
    .push_b    (push_b),
    .din_b     (din_b),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .count_next(count_next),
    .drop      (drop),
    .entry_vld (entry_vld),
    .entry_addr(entry_addr)
  );

  // Output slot and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RF_WRITE     <= 1'b0;
      RF_INADDRESS <= '0;
      RF_IN        <= '0;
      STALL        <= 1'b0;
      PENDING      <= '0;
      OVERFLOW     <= 1'b0;
    end else begin
      if (slot_free) begin
        RF_WRITE <= issue;
        if (issue) begin
          RF_INADDRESS <= zext_addr(issue_req.addr);
          RF_IN        <= issue_req.data;
        end
      end
      STALL    <= (int'(count_next) > DEPTH - 2);
      PENDING  <= PEND_W'(count_next) + PEND_W'(rf_write_next);
      OVERFLOW <= OVERFLOW | drop;
    end
  end

`ifdef REGFILE_WRITE_ARBITER_SCOREBOARD_EN
  always_comb begin
    HAZARD = 1'b0;
    if (RF_WRITE && ((RF_INADDRESS[ADDR_W-1:0] == RD1_ADDR) ||
                     (RF_INADDRESS[ADDR_W-1:0] == RD2_ADDR)))
      HAZARD = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && ((entry_addr[i*ADDR_W +: ADDR_W] == RD1_ADDR) ||
                           (entry_addr[i*ADDR_W +: ADDR_W] == RD2_ADDR)))
        HAZARD = 1'b1;
    end
  end
`else
  logic unused_scoreboard;
  assign unused_scoreboard = ^{RD1_ADDR, RD2_ADDR, entry_vld, entry_addr};
  assign HAZARD = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, and a random run
// against a queue-based model of pending writes.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
`ifdef REGFILE_WRITE_ARBITER_SCOREBOARD_EN
  localparam int HZ_EN = 1;
`else
  localparam int HZ_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, busy, alu_wren, mem_wren;
  logic [2:0] alu_addr, mem_addr, rd1, rd2;
  logic [7:0] alu_data, mem_data;
  logic       rf_write, stall, overflow, hazard;
  logic [7:0] rf_inaddr, rf_in;
  logic [3:0] pending;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct {
    int r, b, aw, aa, ad, mw, ma, md;
    int ew, ea, ed, cd, ep, es, eo;
  } vec_t;

  req_t       q[$];
  vec_t       tbl[$];
  logic       m_stall = 1'b0;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_rf   [8] = '{default: 8'h00};
  logic [7:0] dut_rf [8] = '{default: 8'h00};
  int         commit_cnt [8] = '{default: 0};
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .CLK(clk), .RESET(rst), .BUSYWAIT(busy),
    .ALU_WREN(alu_wren), .ALU_ADDR(alu_addr), .ALU_DATA(alu_data),
    .MEM_WREN(mem_wren), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data),
    .RD1_ADDR(rd1), .RD2_ADDR(rd2),
    .RF_WRITE(rf_write), .RF_INADDRESS(rf_inaddr), .RF_IN(rf_in),
    .STALL(stall), .PENDING(pending), .OVERFLOW(overflow), .HAZARD(hazard)
  );

  // Register file as seen by reg_file: commits on a BUSYWAIT-low edge.
  always @(posedge clk) begin
    if (!rst && rf_write && !busy) begin
      dut_rf[rf_inaddr[2:0]]     <= rf_in;
      commit_cnt[rf_inaddr[2:0]] <= commit_cnt[rf_inaddr[2:0]] + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pending writes form one ordered list; its head is the output slot.
  task automatic model_edge();
    req_t r;
    int   fcnt;
    if (rst) begin
      q.delete();
      m_stall = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      if (q.size() > 0 && !busy) begin
        m_rf[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
      if (mem_wren) begin
        r.addr = mem_addr; r.data = mem_data;
        if (q.size() < DEPTH + 1) q.push_back(r); else m_ovf = 1'b1;
      end
      if (alu_wren && !busy && !m_stall) begin
        r.addr = alu_addr; r.data = alu_data;
        if (q.size() < DEPTH + 1) q.push_back(r); else m_ovf = 1'b1;
      end
      fcnt    = (q.size() > 0) ? q.size() - 1 : 0;
      m_stall = (fcnt > DEPTH - 2);
    end
  endtask

  function automatic int model_hazard();
    int h = 0;
    if (HZ_EN != 0)
      foreach (q[i]) if (q[i].addr == rd1 || q[i].addr == rd2) h = 1;
    return h;
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int r, b, aw, aa, ad, mw, ma, md);
    rst = r[0]; busy = b[0];
    alu_wren = aw[0]; alu_addr = aa[2:0]; alu_data = ad[7:0];
    mem_wren = mw[0]; mem_addr = ma[2:0]; mem_data = md[7:0];
  endtask

  task automatic add(input int r, b, aw, aa, ad, mw, ma, md,
                     input int ew, ea, ed, cd, ep, es, eo);
    vec_t v;
    v = '{r, b, aw, aa, ad, mw, ma, md, ew, ea, ed, cd, ep, es, eo};
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".write"},   int'(rf_write), (q.size() > 0) ? 1 : 0);
    chk({tag, ".pending"}, int'(pending),  q.size());
    chk({tag, ".stall"},   int'(stall),    int'(m_stall));
    chk({tag, ".ovf"},     int'(overflow), int'(m_ovf));
    chk({tag, ".hazard"},  int'(hazard),   model_hazard());
    if (q.size() > 0) begin
      chk({tag, ".addr"}, int'(rf_inaddr), int'(q[0].addr));
      chk({tag, ".data"}, int'(rf_in),     int'(q[0].data));
    end
  endtask

  initial begin
    int snap, tot_before, tot_after;
    rd1 = 3'd0; rd2 = 3'd0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    //   r b aw aa  ad   mw ma  md    ew ea  ed  cd ep es eo
    add(1, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    1, 0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    0, 0, 0, 0);
    add(0, 0, 1, 3, 'h2A, 0, 0, 0,     1, 3, 'h2A, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    0, 0, 0, 0);
    add(0, 0, 1, 5, 'h22, 1, 5, 'h11,  1, 5, 'h11, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0,     1, 5, 'h22, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    0, 0, 0, 0);
    add(0, 1, 0, 0, 0,    1, 1, 'h01,  1, 1, 'h01, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0,    1, 2, 'h02,  1, 1, 'h01, 1, 2, 0, 0);
    add(0, 1, 0, 0, 0,    1, 3, 'h03,  1, 1, 'h01, 1, 3, 0, 0);
    add(0, 1, 0, 0, 0,    1, 4, 'h04,  1, 1, 'h01, 1, 4, 1, 0);
    add(0, 1, 0, 0, 0,    1, 5, 'h05,  1, 1, 'h01, 1, 5, 1, 0);
    add(0, 1, 0, 0, 0,    1, 6, 'h06,  1, 1, 'h01, 1, 5, 1, 1);
    add(0, 1, 0, 0, 0,    0, 0, 0,     1, 1, 'h01, 1, 5, 1, 1);
    add(0, 0, 0, 0, 0,    0, 0, 0,     1, 2, 'h02, 1, 4, 1, 1);
    add(0, 0, 1, 7, 'h77, 0, 0, 0,     1, 3, 'h03, 1, 3, 0, 1);
    add(1, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0,    1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].r, tbl[i].b, tbl[i].aw, tbl[i].aa, tbl[i].ad,
             tbl[i].mw, tbl[i].ma, tbl[i].md);
      cycle();
      chk($sformatf("v%0d.write", i),   int'(rf_write), tbl[i].ew);
      chk($sformatf("v%0d.pending", i), int'(pending),  tbl[i].ep);
      chk($sformatf("v%0d.stall", i),   int'(stall),    tbl[i].es);
      chk($sformatf("v%0d.ovf", i),     int'(overflow), tbl[i].eo);
      chk($sformatf("v%0d.hazard", i),  int'(hazard),   0);
      if (tbl[i].cd != 0) begin
        chk($sformatf("v%0d.addr", i), int'(rf_inaddr), tbl[i].ea);
        chk($sformatf("v%0d.data", i), int'(rf_in),     tbl[i].ed);
      end
    end

    // Slot held stable across BUSYWAIT, committed exactly once.
    set_in(0, 0, 1, 2, 'h5C, 0, 0, 0);
    cycle();
    snap = commit_cnt[2];
    chk("hold.issue", int'(rf_write), 1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 0);
      cycle();
      chk($sformatf("hold%0d.write", i), int'(rf_write),  1);
      chk($sformatf("hold%0d.addr", i),  int'(rf_inaddr), 2);
      chk($sformatf("hold%0d.data", i),  int'(rf_in),     'h5C);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("hold.retired", int'(rf_write), 0);
    chk("hold.commits", commit_cnt[2] - snap, 1);
    cycle();
    chk("hold.commits_after", commit_cnt[2] - snap, 1);
    chk("hold.reg2", int'(dut_rf[2]), 'h5C);

    // Reset discards queued and issued writes.
    set_in(0, 1, 0, 0, 0, 1, 1, 'hA1); cycle();
    set_in(0, 1, 0, 0, 0, 1, 2, 'hA2); cycle();
    set_in(0, 1, 0, 0, 0, 1, 3, 'hA3); cycle();
    chk("rst.pre_pending", int'(pending), 3);
    tot_before = 0;
    foreach (commit_cnt[i]) tot_before += commit_cnt[i];
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("rst.write",   int'(rf_write),  0);
    chk("rst.addr",    int'(rf_inaddr), 0);
    chk("rst.data",    int'(rf_in),     0);
    chk("rst.pending", int'(pending),   0);
    chk("rst.stall",   int'(stall),     0);
    chk("rst.ovf",     int'(overflow),  0);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
      chk($sformatf("rst.idle%0d", i), int'(rf_write), 0);
    end
    tot_after = 0;
    foreach (commit_cnt[i]) tot_after += commit_cnt[i];
    chk("rst.no_commit", tot_after - tot_before, 0);

    // Read-after-pending-write detection on the slot and on FIFO entries.
    rd1 = 3'd4; rd2 = 3'd0;
    set_in(0, 1, 0, 0, 0, 1, 4, 'h44); cycle();
    chk("hz.slot", int'(hazard), HZ_EN);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("hz.retired", int'(hazard), 0);
    rd1 = 3'd0; rd2 = 3'd7;
    set_in(0, 1, 0, 0, 0, 1, 1, 'h01); cycle();
    set_in(0, 1, 0, 0, 0, 1, 7, 'h07); cycle();
    chk("hz.fifo", int'(hazard), HZ_EN);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("hz.slot2", int'(hazard), HZ_EN);
    cycle();
    chk("hz.clear", int'(hazard), 0);

    // Random traffic against the model.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); cycle();
    check_model("rnd_rst");
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 99) == 0) ? 1 : 0,
             ($urandom_range(0, 9) < 4) ? 1 : 0,
             int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      rd1 = 3'($urandom_range(0, 7));
      rd2 = 3'($urandom_range(0, 7));
      cycle();
      check_model($sformatf("rnd%0d", n));
    end
    for (int n = 0; n < DEPTH + 3; n++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check_model($sformatf("drain%0d", n));
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("reg%0d", i), int'(dut_rf[i]), int'(m_rf[i]));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
